// File: rtl/frame_dispatch_ctrl.sv
// Captures SPI sample bytes into a 2*FFT_SIZE circular buffer and dispatches overlapping
// analysis frames (hop HOP) to an FFT core through a load/start/done handshake.
module frame_dispatch_ctrl #(
    parameter int unsigned DW            = 8,
    parameter int unsigned N             = 9,
    parameter int unsigned FFT_SIZE      = 512,
    parameter int unsigned HOP           = 256,
    parameter bit          OFFSET_BINARY = 1'b1,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             spi_tran_done,
    input  logic [DW-1:0]    din_spi,
    input  logic             fft_done,
    output logic             fft_load,
    output logic [N-1:0]     fft_addr,
    output logic [DW-1:0]    fft_data,
    output logic             fft_start,
    output logic             busy,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             overrun
);

    localparam int unsigned AW    = N + 1;
    localparam int unsigned CW    = AW + 1;
    localparam int unsigned SW    = CNT_W + AW;
    localparam int unsigned DEPTH = 2 * FFT_SIZE;

    localparam logic [AW-1:0] FrameA   = AW'(FFT_SIZE);
    localparam logic [AW-1:0] HopA     = AW'(HOP);
    localparam logic [AW-1:0] HopMax   = AW'(DEPTH - 1);
    localparam logic [CW-1:0] Hop2C    = CW'(2 * HOP);
    localparam logic [N-1:0]  LastBeat = N'(FFT_SIZE - 1);

    typedef enum logic [2:0] {StFill, StWait, StLoad, StStart, StCalc} state_e;

    state_e state_q, state_d;
    logic   load_go;

    logic [1:0]       rst_sync_q;
    logic             rst_n;
    logic [2:0]       sync_q;
    logic             sample_stb;
    logic [DW-1:0]    wdata;
    logic [AW-1:0]    wr_ptr_q, base_q, rd_addr;
    logic [AW-1:0]    fill_cnt_q, hop_cnt_q, drop_inc;
    logic [N-1:0]     beat_q;
    logic             first_sent_q, overrun_q, hop_over;
    logic [CNT_W-1:0] frame_cnt_q, drop_cnt_q;
    logic [SW-1:0]    drop_sum;
    logic [DW-1:0]    mem_q [DEPTH];
    logic [DW-1:0]    rd_data_q;

    // Reset asserts asynchronously, releases two clocks after reset rises.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync_q <= '0;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    assign sample_stb = sync_q[1] & ~sync_q[2];
    assign wdata      = {din_spi[DW-1] ^ OFFSET_BINARY, din_spi[DW-2:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StFill;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load_go = 1'b0;
        unique case (state_q)
            StFill:  if (fill_cnt_q == FrameA) state_d = StWait;
            StWait: begin
                if (!first_sent_q || hop_cnt_q >= HopA) begin
                    state_d = StLoad;
                    load_go = 1'b1;
                end
            end
            StLoad:  if (beat_q == LastBeat) state_d = StStart;
            StStart: state_d = StCalc;
            StCalc:  if (fft_done) state_d = StWait;
            default: state_d = StFill;
        endcase
    end

    always_comb begin
        fft_load  = (state_q == StLoad);
        fft_start = (state_q == StStart);
        busy      = (state_q == StLoad) || (state_q == StStart) || (state_q == StCalc);
        fft_addr  = fft_load ? beat_q : '0;
        fft_data  = fft_load ? rd_data_q : '0;
    end

    assign frame_cnt = frame_cnt_q;
    assign drop_cnt  = drop_cnt_q;
    assign overrun   = overrun_q;

    // The frame ends at the newest sample written before the LOAD decision.
    always_comb begin
        rd_addr  = load_go ? (wr_ptr_q - FrameA) : (base_q + AW'(beat_q) + AW'(1));
        hop_over = CW'(hop_cnt_q) >= Hop2C;
        drop_inc = hop_cnt_q / HopA - AW'(1);
        drop_sum = SW'(drop_cnt_q) + SW'(drop_inc);
    end

    always_ff @(posedge clk) begin
        if (sample_stb) mem_q[wr_ptr_q] <= wdata;
        rd_data_q <= mem_q[rd_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q       <= '0;
            wr_ptr_q     <= '0;
            base_q       <= '0;
            fill_cnt_q   <= '0;
            hop_cnt_q    <= '0;
            beat_q       <= '0;
            first_sent_q <= 1'b0;
            frame_cnt_q  <= '0;
            drop_cnt_q   <= '0;
            overrun_q    <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], spi_tran_done};
            if (sample_stb) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
                if (fill_cnt_q != FrameA) fill_cnt_q <= fill_cnt_q + AW'(1);
            end
            if (load_go) begin
                hop_cnt_q    <= sample_stb ? AW'(1) : '0;
                base_q       <= wr_ptr_q - FrameA;
                beat_q       <= '0;
                frame_cnt_q  <= frame_cnt_q + CNT_W'(1);
                first_sent_q <= 1'b1;
                if (first_sent_q && hop_over) begin
                    drop_cnt_q <= (|drop_sum[SW-1:CNT_W]) ? '1 : drop_sum[CNT_W-1:0];
                    overrun_q  <= 1'b1;
                end
            end else begin
                if (sample_stb && hop_cnt_q != HopMax) hop_cnt_q <= hop_cnt_q + AW'(1);
                if (state_q == StLoad) beat_q <= beat_q + N'(1);
            end
        end
    end

endmodule

// File: tb/tb_frame_dispatch_ctrl.sv
// Directed bench for frame_dispatch_ctrl with FFT_SIZE=8, HOP=4; a second instance with
// OFFSET_BINARY=0 shares the stimulus so raw storage is checked alongside.
module tb_frame_dispatch_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       spi = 1'b0;
    logic       done = 1'b0;
    logic [7:0] din = 8'h00;

    logic       fft_load, fft_start, busy, overrun;
    logic [2:0] fft_addr;
    logic [7:0] fft_data, frame_cnt, drop_cnt;
    logic       r_load, r_start, r_busy, r_overrun;
    logic [2:0] r_addr;
    logic [7:0] r_data, r_frame, r_drop;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] exp_frame [8];

    frame_dispatch_ctrl #(.DW(8), .N(3), .FFT_SIZE(8), .HOP(4), .OFFSET_BINARY(1'b1), .CNT_W(8))
    u_dut (
        .clk(clk), .reset(reset), .spi_tran_done(spi), .din_spi(din), .fft_done(done),
        .fft_load(fft_load), .fft_addr(fft_addr), .fft_data(fft_data), .fft_start(fft_start),
        .busy(busy), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt), .overrun(overrun)
    );

    frame_dispatch_ctrl #(.DW(8), .N(3), .FFT_SIZE(8), .HOP(4), .OFFSET_BINARY(1'b0), .CNT_W(8))
    u_raw (
        .clk(clk), .reset(reset), .spi_tran_done(spi), .din_spi(din), .fft_done(done),
        .fft_load(r_load), .fft_addr(r_addr), .fft_data(r_data), .fft_start(r_start),
        .busy(r_busy), .frame_cnt(r_frame), .drop_cnt(r_drop), .overrun(r_overrun)
    );

    always #5 clk = ~clk;

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        din = b;
        spi = 1'b1;
        step(2);
        spi = 1'b0;
        step(2);
    endtask

    task automatic pulse_done();
        done = 1'b1;
        step(1);
        done = 1'b0;
    endtask

    task automatic wait_load(input string tag);
        int n = 0;
        while (!fft_load && n < 40) begin
            step(1);
            n++;
        end
        check({tag, " load_seen"}, 32'(fft_load), 32'd1);
    endtask

    task automatic check_beats(input string tag, input int nbeats, input int done_at);
        for (int i = 0; i < nbeats; i++) begin
            check({tag, " load"}, 32'(fft_load), 32'd1);
            check({tag, " addr"}, 32'(fft_addr), 32'(i));
            check({tag, " data"}, 32'(fft_data), 32'(exp_frame[i]));
            check({tag, " raw_data"}, 32'(r_data), 32'(exp_frame[i] ^ 8'h80));
            check({tag, " no_start"}, 32'(fft_start), 32'd0);
            done = (i == done_at);
            if (i != nbeats - 1) step(1);
        end
        done = 1'b0;
    endtask

    task automatic check_tail(input string tag);
        step(1);
        check({tag, " start"}, 32'(fft_start), 32'd1);
        check({tag, " load_off"}, 32'(fft_load), 32'd0);
        step(1);
        check({tag, " start_once"}, 32'(fft_start), 32'd0);
        check({tag, " busy_calc"}, 32'(busy), 32'd1);
    endtask

    task automatic check_counts(input string tag, input int fc, input int dc, input int ov);
        check({tag, " frame_cnt"}, 32'(frame_cnt), 32'(fc));
        check({tag, " drop_cnt"}, 32'(drop_cnt), 32'(dc));
        check({tag, " overrun"}, 32'(overrun), 32'(ov));
    endtask

    initial begin
        // Reset and idle
        step(5);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1);
            check("idle outputs", 32'({fft_load, fft_start, busy, overrun, fft_addr, fft_data,
                                       frame_cnt, drop_cnt}), 32'd0);
        end

        // First frame
        for (int i = 0; i < 8; i++) send_byte(8'h80 + 8'(i));
        wait_load("f1");
        for (int i = 0; i < 8; i++) exp_frame[i] = 8'(i);
        check_beats("f1", 8, -1);
        check_tail("f1");
        check_counts("f1", 1, 0, 0);

        // Overlapping second frame
        pulse_done();
        step(2);
        check("f2 idle_wait", 32'(busy), 32'd0);
        for (int i = 0; i < 4; i++) send_byte(8'h88 + 8'(i));
        wait_load("f2");
        for (int i = 0; i < 8; i++) exp_frame[i] = 8'h04 + 8'(i);
        check_beats("f2", 8, -1);
        check_tail("f2");
        check_counts("f2", 2, 0, 0);

        // Drop: 12 samples while the FFT is busy; done during LOAD must be ignored
        for (int i = 0; i < 12; i++) send_byte(8'h8C + 8'(i));
        check("f3 held_calc", 32'({busy, fft_load}), 32'b10);
        check("f3 no_drop_yet", 32'(drop_cnt), 32'd0);
        pulse_done();
        wait_load("f3");
        for (int i = 0; i < 8; i++) exp_frame[i] = 8'h10 + 8'(i);
        check_beats("f3", 8, 3);
        check_tail("f3");
        check_counts("f3", 3, 2, 1);
        step(5);
        check("f3 still_calc", 32'({busy, fft_load, fft_start}), 32'b100);

        // Level held high for 10 clk gives one write
        din = 8'hA0;
        spi = 1'b1;
        step(10);
        spi = 1'b0;
        step(3);
        for (int i = 1; i < 4; i++) send_byte(8'hA0 + 8'(i));
        check("f4 held_calc", 32'(busy), 32'd1);
        pulse_done();
        wait_load("f4");
        exp_frame = '{8'h14, 8'h15, 8'h16, 8'h17, 8'h20, 8'h21, 8'h22, 8'h23};
        check_beats("f4", 8, -1);
        check_tail("f4");
        check_counts("f4", 4, 2, 1);

        // Strobe coincident with LOAD entry is excluded from the frame
        for (int i = 0; i < 4; i++) send_byte(8'hB0 + 8'(i));
        din = 8'hB4;
        spi = 1'b1;
        step(1);
        done = 1'b1;
        step(1);
        done = 1'b0;
        spi = 1'b0;
        wait_load("f5");
        exp_frame = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h30, 8'h31, 8'h32, 8'h33};
        check_beats("f5", 8, -1);
        check_tail("f5");
        check_counts("f5", 5, 2, 1);

        // Coincident sample counts toward the next hop; reset at beat 3 aborts the frame
        for (int i = 0; i < 3; i++) send_byte(8'hC0 + 8'(i));
        pulse_done();
        wait_load("f6");
        exp_frame = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h40, 8'h41, 8'h42};
        check_beats("f6", 4, -1);
        reset = 1'b0;
        #1;
        check("rst load_drop", 32'({fft_load, busy, fft_start}), 32'd0);
        check_counts("rst", 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("rst no_start", 32'({fft_start, fft_load}), 32'd0);
        end
        reset = 1'b1;
        step(3);
        for (int i = 0; i < 7; i++) send_byte(8'hD0 + 8'(i));
        step(5);
        check("rst fill_7", 32'({fft_load, busy}), 32'd0);
        send_byte(8'hD7);
        wait_load("f7");
        for (int i = 0; i < 8; i++) exp_frame[i] = 8'h50 + 8'(i);
        check_beats("f7", 8, -1);
        check_tail("f7");
        check_counts("f7", 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_dispatch_ctrl.md
Name: frame_dispatch_ctrl

Overview:
- Parametrised successor to the single-shot SPI-to-FFT controller.
- Captures samples from an asynchronous SPI byte-done strobe into an internal circular buffer.
- Dispatches overlapping analysis frames (hop size HOP) to the FFT core through a load/start/done handshake.
- Keeps capturing while the FFT computes, and counts frames that were dispatched and frames that were skipped.

Parameters:
- DW, 8: sample width in bits.
- N, 9: log2(FFT_SIZE); width of fft_addr.
- FFT_SIZE, 512: samples per frame; must equal 2^N.
- HOP, 256: new samples between frame starts; 1 <= HOP <= FFT_SIZE.
- OFFSET_BINARY, 1: 1 = invert sample MSB on capture (offset-binary to two's complement); 0 = store raw.
- CNT_W, 8: width of frame_cnt and drop_cnt.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-low reset.
- spi_tran_done  in  1  SPI byte-complete level, asynchronous to clk.
- din_spi  in  DW  sample byte; stable for at least 4 clk after spi_tran_done rises.
- fft_done  in  1  FFT core finished; single-cycle pulse or level.
- fft_load  out  1  fft_addr/fft_data valid this cycle.
- fft_addr  out  N  frame index, 0 = oldest sample.
- fft_data  out  DW  sample for fft_addr.
- fft_start  out  1  one-cycle pulse after the last load beat.
- busy  out  1  high in LOAD, START and CALC.
- frame_cnt  out  CNT_W  frames dispatched; wraps.
- drop_cnt  out  CNT_W  frames skipped; saturates at all-ones.
- overrun  out  1  sticky; set on the first drop, cleared only by reset.

Behaviour:
- Reset: asserting reset clears all state asynchronously. Deassertion passes through a 2-flop synchroniser (rst_n); logic leaves reset 2 clk after release.
- Reset outputs: all outputs 0; state FILL; pointers and counters 0. Buffer contents are not cleared.
- Reset mid-LOAD/CALC aborts the frame. No fft_start is issued for it.
- Capture: spi_tran_done goes through 3 flops. sample_stb = sync2 & ~sync3, i.e. one pulse per rising edge, 2-3 clk after the edge.
- On sample_stb: write din_spi (MSB inverted if OFFSET_BINARY) to buf[wr_ptr]; wr_ptr++.
- Buffer: depth 2*FFT_SIZE, index width N+1; wr_ptr wraps naturally at 2*FFT_SIZE.
- Capture continues in every state. Reads and writes never collide within one frame, because LOAD lasts FFT_SIZE clk and the buffer depth is 2*FFT_SIZE.
- Counters: fill_cnt counts samples since reset and saturates at FFT_SIZE. hop_cnt counts samples since the last dispatch and saturates at 2*FFT_SIZE-1.
- FILL: go to WAIT when fill_cnt reaches FFT_SIZE. The first frame is dispatched without a hop requirement.
- WAIT: go to LOAD when the first frame has not yet been sent, or when hop_cnt >= HOP.
- LOAD entry (cycle T):
  - base = wr_ptr - FFT_SIZE (mod 2*FFT_SIZE), using wr_ptr as registered at T.
  - If hop_cnt >= 2*HOP: drop_cnt += floor(hop_cnt/HOP) - 1 (saturating), and overrun <= 1.
  - hop_cnt <= 0, plus 1 if sample_stb is active at T.
  - frame_cnt++.
- Dispatched frame always ends at the newest sample.
- LOAD: read address base+i is issued at T+i for i = 0..FFT_SIZE-1. The read is registered, so fft_load=1, fft_addr=i and fft_data=buf[base+i] appear at T+1+i.
- START: fft_start=1 for exactly one cycle at T+FFT_SIZE+1. fft_load is 0 in that cycle.
- CALC: wait for fft_done sampled high. fft_done seen outside CALC is ignored.
- CALC exit: on fft_done go to WAIT. If hop_cnt >= HOP at that point, LOAD begins on the next cycle.
- Simultaneous sample_stb and LOAD entry: the write completes first. The frame excludes that sample, and it counts toward the next hop.
- HOP = FFT_SIZE: non-overlapping frames.

Test Plan (N=3, FFT_SIZE=8, HOP=4, DW=8, OFFSET_BINARY=1 unless noted):
- Reset/idle: hold reset low 5 clk, release, run 20 clk with no strobes → all outputs 0, busy=0, no fft_load.
- First frame: send bytes 0x80..0x87 → 8 load beats, fft_addr 0..7, fft_data 0x00..0x07. fft_start pulses exactly 1 clk after the last beat. frame_cnt=1.
- Overlap: pulse fft_done, then send 0x88..0x8B → second frame carries fft_data 0x04..0x0B. frame_cnt=2. OFFSET_BINARY=0 run: same stimulus gives fft_data 0x84..0x8B.
- Drop: withhold fft_done while 12 samples arrive, then pulse it → the next frame holds the newest 8 samples. drop_cnt=2, overrun=1 and stays 1.
- Async edge cases: hold spi_tran_done high for 10 clk → exactly one write. A strobe coincident with LOAD entry is excluded from that frame. An fft_done pulse during LOAD is ignored and the FSM stays in CALC.
- Reset mid-LOAD at beat 3 → fft_load drops immediately, no fft_start. After release the FSM restarts in FILL and needs 8 new samples.
